// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the memory-access stage (master) and the data-memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid_i;
  logic        req_write_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic        req_ready_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_error_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: 64-bit little-endian accesses at any byte address into a byte store,
// with a fixed wait-state latency and an out-of-range error response.
module data_mem_responder #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  data_mem_responder_if.slave  bus
);
  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_ready, w_ready_nxt;
  logic          r_rsp_valid, w_valid_nxt;
  logic [63:0]   r_rdata, w_rdata_nxt;
  logic          r_error, w_error_nxt;
  logic          r_write;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic          w_accept;
  logic          w_commit;
  logic          w_range_err;
  logic [AW-1:0] w_base;
  logic [63:0]   w_rd_word;

  logic [7:0]    r_mem [MEM_BYTES];

  // Unsigned compare with no wrap: any address whose 8-byte window leaves the store is an error.
  assign w_range_err = (r_addr > 64'(MEM_BYTES - 8));
  assign w_base      = r_addr[AW-1:0];

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      w_rd_word[8*i +: 8] = r_mem[w_base + AW'(i)];
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    w_valid_nxt = r_rsp_valid;
    w_rdata_nxt = r_rdata;
    w_error_nxt = r_error;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid_i) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CW'(LATENCY - 1);
          w_ready_nxt = 1'b0;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
          w_valid_nxt = 1'b1;
          w_error_nxt = w_range_err;
          w_rdata_nxt = (w_range_err || r_write) ? 64'd0 : w_rd_word;
          w_commit    = r_write && !w_range_err && !rst_i;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
          w_ready_nxt = 1'b1;
          w_rdata_nxt = 64'd0;
          w_error_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_error     <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ready     <= w_ready_nxt;
      r_rsp_valid <= w_valid_nxt;
      r_rdata     <= w_rdata_nxt;
      r_error     <= w_error_nxt;
      if (w_accept) begin
        r_write <= bus.req_write_i;
        r_addr  <= bus.req_addr_i;
        r_wdata <= bus.req_wdata_i;
      end
    end
  end

  // Byte store has no reset; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      for (int i = 0; i < 8; i++) begin
        r_mem[w_base + AW'(i)] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready_o = r_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rdata;
  assign bus.rsp_error_o = r_error;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with hand-computed expectations.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  data_mem_responder_if bus ();

  data_mem_responder #(.MEM_BYTES(1024), .LATENCY(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%h exp=0x%h", tag, obs, exp);
    end
  endtask

  // Issue one request, confirm the 2-edge latency, take the response.
  task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                     output logic [63:0] rd, output logic er);
    int n;
    @(negedge clk);
    check("idle_ready", 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = w;
    bus.req_addr_i  = a;
    bus.req_wdata_i = d;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.req_write_i = ~w;
    bus.req_addr_i  = '1;
    bus.req_wdata_i = '1;
    n = 0;
    while (!bus.rsp_valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'd2);
    check("busy_ready", 64'(bus.req_ready_o), 64'd0);
    rd = bus.rsp_rdata_o;
    er = bus.rsp_error_o;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    check("rsp_drop", 64'(bus.rsp_valid_o), 64'd0);
    check("back_idle", 64'(bus.req_ready_o), 64'd1);
  endtask

  logic [63:0] rd;
  logic        er;

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.rsp_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready_o), 64'd1);
    check("rst_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_rdata", bus.rsp_rdata_o, 64'd0);
    check("rst_error", 64'(bus.rsp_error_o), 64'd0);
    rst = 1'b0;

    // Basic write/read and call/ret pair
    txn(1'b1, 64'd112, 64'h80, rd, er);
    check("w112_err", 64'(er), 64'd0);
    check("w112_rd", rd, 64'd0);
    txn(1'b0, 64'd112, 64'd0, rd, er);
    check("r112_err", 64'(er), 64'd0);
    check("r112_rd", rd, 64'h80);
    txn(1'b1, 64'd120, 64'h40, rd, er);
    check("w120_err", 64'(er), 64'd0);
    txn(1'b0, 64'd120, 64'd0, rd, er);
    check("r120_rd", rd, 64'h40);

    // Range errors; store must not change
    txn(1'b1, 64'd1016, 64'hA5A5_5A5A_C3C3_3C3C, rd, er);
    check("w1016_err", 64'(er), 64'd0);
    txn(1'b0, 64'd1024, 64'd0, rd, er);
    check("r1024_err", 64'(er), 64'd1);
    check("r1024_rd", rd, 64'd0);
    txn(1'b0, 64'd1017, 64'd0, rd, er);
    check("r1017_err", 64'(er), 64'd1);
    check("r1017_rd", rd, 64'd0);
    txn(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_DEAD_BEEF, rd, er);
    check("wneg_err", 64'(er), 64'd1);
    check("wneg_rd", rd, 64'd0);
    txn(1'b1, 64'd1017, 64'h1111_2222_3333_4444, rd, er);
    check("w1017_err", 64'(er), 64'd1);
    txn(1'b0, 64'd1016, 64'd0, rd, er);
    check("r1016_err", 64'(er), 64'd0);
    check("r1016_rd", rd, 64'hA5A5_5A5A_C3C3_3C3C);
    txn(1'b0, 64'd112, 64'd0, rd, er);
    check("r112_again", rd, 64'h80);

    // Unaligned
    txn(1'b1, 64'd3, 64'h1122_3344_5566_7788, rd, er);
    check("w3_err", 64'(er), 64'd0);
    txn(1'b0, 64'd3, 64'd0, rd, er);
    check("r3_rd", rd, 64'h1122_3344_5566_7788);
    txn(1'b0, 64'd4, 64'd0, rd, er);
    check("r4_rd_low56", rd & 64'h00FF_FFFF_FFFF_FFFF, 64'h0011_2233_4455_6677);

    // Backpressure: response held stable, new requests ignored
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = 64'd112;
    @(posedge clk); #1;
    bus.req_write_i = 1'b1;
    bus.req_addr_i  = 64'd120;
    bus.req_wdata_i = 64'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(bus.rsp_valid_o), 64'd1);
      check("bp_rdata", bus.rsp_rdata_o, 64'h80);
      check("bp_error", 64'(bus.rsp_error_o), 64'd0);
      check("bp_ready", 64'(bus.req_ready_o), 64'd0);
      @(posedge clk); #1;
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    check("bp_release_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("bp_release_ready", 64'(bus.req_ready_o), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check("bp_no_extra", 64'(bus.rsp_valid_o), 64'd0);
    txn(1'b0, 64'd120, 64'd0, rd, er);
    check("bp_120_kept", rd, 64'h40);

    // Reset during WAIT aborts a write
    txn(1'b1, 64'd200, 64'h0102_0304_0506_0708, rd, er);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b1;
    bus.req_addr_i  = 64'd200;
    bus.req_wdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstw_ready", 64'(bus.req_ready_o), 64'd1);
    check("rstw_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rstw_rdata", bus.rsp_rdata_o, 64'd0);
    check("rstw_error", 64'(bus.rsp_error_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstw_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    txn(1'b0, 64'd200, 64'd0, rd, er);
    check("rstw_old", rd, 64'h0102_0304_0506_0708);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
